voice_allocator: RTL and testbench
==================================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_KEYS, default 8: number of key inputs.
REQ-002 Parameter NUM_VOICES, default 4: number of oscillator voices shared among the keys.
REQ-003 CLK  input  1  single system clock; all state changes on posedge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 Enable  input  1  allocator active; low releases all voices.
REQ-006 keys  input  NUM_KEYS  level key-on requests, bit i = key i held.
REQ-007 voice_on  output  NUM_VOICES  bit v high while voice v sounds.
REQ-008 voice_key  output  NUM_VOICES x clog2(NUM_KEYS)  key index assigned to each voice.
REQ-009 voice_trig  output  NUM_VOICES  one-cycle pulse on each new assignment to voice v, including steals.
REQ-010 steal  output  1  one-cycle pulse when the assignment in that cycle evicted an active voice.

Function
REQ-011 Internal key_q register SHALL hold the previous cycle's keys; rise = keys AND NOT key_q.
REQ-012 Pending mask SHALL update to (pending OR rise) AND keys each cycle; released keys drop out of pending unserviced.
REQ-013 At most one key SHALL be allocated per cycle: the lowest-index set bit of (pending OR rise) AND keys; the allocated bit is cleared from pending.
REQ-014 Latency: a key first sampled high at edge k SHALL appear on voice_on/voice_key/voice_trig after edge k if no other key is waiting; otherwise one further cycle per lower-index waiting key.
REQ-015 Target voice SHALL be the lowest-index voice with voice_on low; if all voices are on, the voice with rank NUM_VOICES-1 (oldest) SHALL be stolen and steal pulsed.
REQ-016 Each voice SHALL hold a rank 0..NUM_VOICES-1, all ranks distinct, 0 = most recent; on allocation to voice v with old rank r, every voice with rank < r increments and v takes rank 0; other ranks are unchanged.
REQ-017 When keys bit i is low, every voice with voice_on high and voice_key = i SHALL clear voice_on after that edge; voice_key and rank are retained.
REQ-018 A release for a key held by no voice (stolen or never serviced) SHALL have no effect.
REQ-019 Release of one key and allocation of a different key in the same cycle SHALL both take effect; a voice freed in that cycle is not a candidate for that cycle's allocation.
REQ-020 A key that rises and is low again before service SHALL never be allocated.
REQ-021 voice_trig and steal SHALL be registered and high for exactly one cycle per allocation.
REQ-022 While Enable is low: voice_on, pending, voice_trig and steal SHALL be forced to 0 and key_q SHALL be forced to 0, so that keys held at re-enable are treated as new presses.
REQ-023 Allocation SHALL resume on the first edge at which Enable is high.

Reset
REQ-024 On RESET high, asynchronously: voice_on=0, voice_key=0, voice_trig=0, steal=0, pending=0, key_q=0, rank[v]=v.
REQ-025 RESET asserted mid-allocation SHALL discard pending work; no pulse SHALL appear after reset deassertion without a new rise.

Structure
REQ-026 NUM_KEYS, NUM_VOICES defaults and the key-index type SHALL reside in the shared package synth_pkg.
REQ-027 One sub-module, prio_enc (lowest-set-bit priority encoder with valid flag), SHALL be used for both key selection and free-voice selection.

Verification
REQ-028 Reset, Enable=1, keys=8'b00000100 -> after next edge voice_on=0001, voice_key[0]=2, voice_trig=0001 for one cycle.
REQ-029 keys 0,1,2,3 rising in one cycle -> voices 0..3 assigned keys 0..3 on four consecutive edges, one voice_trig pulse each, steal never high.
REQ-030 Four voices active (keys 0..3 pressed in order), then key 5 pressed -> voice 0 gets key 5, voice_on stays 1111, steal and voice_trig=0001 pulse together; later release of key 0 changes nothing.
REQ-031 keys 0..4 pressed in one cycle, key 4 released before service -> key 4 never allocated; releasing key 1 then frees voice 1, voice_on=1101.
REQ-032 Enable dropped with keys 0,1 held -> voice_on=0000 next edge; Enable raised -> keys 0,1 re-allocated with fresh voice_trig pulses.
REQ-033 RESET asserted asynchronously between edges while keys pending -> all outputs 0 immediately and ranks 0..3 restored.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared defaults for the synth voice blocks: key/voice counts and the key-index type.
package synth_pkg;
  localparam int DEFAULT_NUM_KEYS   = 8;
  localparam int DEFAULT_NUM_VOICES = 4;
  localparam int KEY_W              = $clog2(DEFAULT_NUM_KEYS);
  localparam int RANK_W             = $clog2(DEFAULT_NUM_VOICES);

  typedef logic [KEY_W-1:0]  key_idx_t;
  typedef logic [RANK_W-1:0] rank_t;
endpackage

// File: rtl/voice_allocator_if.sv
// Key requests in, voice state out. voice_rank is an observation port (0 = newest voice).
interface voice_allocator_if
  import synth_pkg::*;
#(
  parameter int NUM_KEYS   = DEFAULT_NUM_KEYS,
  parameter int NUM_VOICES = DEFAULT_NUM_VOICES
);
  localparam int KW = $clog2(NUM_KEYS);
  localparam int RW = $clog2(NUM_VOICES);

  // Level interface, no handshake: keys are sampled every CLK edge while Enable is
  // high; voice_trig/steal are single-cycle registered pulses, never back-pressured.
  logic                           Enable;
  logic [NUM_KEYS-1:0]            keys;
  logic [NUM_VOICES-1:0]          voice_on;
  logic [NUM_VOICES-1:0][KW-1:0]  voice_key;
  logic [NUM_VOICES-1:0]          voice_trig;
  logic                           steal;
  logic [NUM_VOICES-1:0][RW-1:0]  voice_rank;

  modport master (
    output Enable, keys,
    input  voice_on, voice_key, voice_trig, steal, voice_rank
  );

  modport slave (
    input  Enable, keys,
    output voice_on, voice_key, voice_trig, steal, voice_rank
  );
endinterface

// File: rtl/prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module prio_enc #(
  parameter int W = 8,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);
  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end
endmodule

// File: rtl/voice_allocator.sv
// Assigns held keys to a small pool of voices, one allocation per cycle,
// stealing the oldest voice when none is free.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_KEYS   = DEFAULT_NUM_KEYS,
  parameter int NUM_VOICES = DEFAULT_NUM_VOICES
) (
  input logic              CLK,
  input logic              RESET,
  voice_allocator_if.slave bus
);
  localparam int KW = $clog2(NUM_KEYS);
  localparam int RW = $clog2(NUM_VOICES);

  logic [NUM_KEYS-1:0]            key_q, pending, rise, cand, alloc_mask;
  logic                           key_valid, free_valid;
  logic [KW-1:0]                  key_idx;
  logic [RW-1:0]                  free_idx, oldest_idx, target;
  logic [NUM_VOICES-1:0]          voice_on_q, voice_on_d, trig_q, trig_d, free_vec;
  logic                           steal_q, steal_d;
  logic [NUM_VOICES-1:0][KW-1:0]  vkey_q, vkey_d;
  logic [NUM_VOICES-1:0][RW-1:0]  rank_q, rank_d;

  assign rise     = bus.keys & ~key_q;
  assign cand     = (pending | rise) & bus.keys;
  assign free_vec = ~voice_on_q;

  prio_enc #(.W(NUM_KEYS)) u_key_enc (
    .req   (cand),
    .valid (key_valid),
    .idx   (key_idx)
  );

  prio_enc #(.W(NUM_VOICES)) u_free_enc (
    .req   (free_vec),
    .valid (free_valid),
    .idx   (free_idx)
  );

  always_comb begin
    oldest_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rank_q[v] == RW'(NUM_VOICES - 1)) oldest_idx = RW'(v);
    end
  end

  // Free voices come from the registered voice_on, so a voice released this cycle
  // only becomes a candidate on the next one.
  assign target     = free_valid ? free_idx : oldest_idx;
  assign alloc_mask = key_valid ? (NUM_KEYS'(1) << key_idx) : '0;

  always_comb begin
    voice_on_d = voice_on_q;
    vkey_d     = vkey_q;
    rank_d     = rank_q;
    trig_d     = '0;
    steal_d    = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voice_on_q[v] && !bus.keys[vkey_q[v]]) voice_on_d[v] = 1'b0;
    end
    if (key_valid) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (rank_q[v] < rank_q[target]) rank_d[v] = rank_q[v] + RW'(1);
      end
      rank_d[target]     = '0;
      vkey_d[target]     = key_idx;
      voice_on_d[target] = 1'b1;
      trig_d[target]     = 1'b1;
      steal_d            = !free_valid;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      key_q      <= '0;
      pending    <= '0;
      voice_on_q <= '0;
      vkey_q     <= '0;
      trig_q     <= '0;
      steal_q    <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= RW'(v);
    end else if (!bus.Enable) begin
      // Clearing key_q makes keys still held at re-enable look like fresh presses.
      key_q      <= '0;
      pending    <= '0;
      voice_on_q <= '0;
      trig_q     <= '0;
      steal_q    <= 1'b0;
    end else begin
      key_q      <= bus.keys;
      pending    <= cand & ~alloc_mask;
      voice_on_q <= voice_on_d;
      vkey_q     <= vkey_d;
      rank_q     <= rank_d;
      trig_q     <= trig_d;
      steal_q    <= steal_d;
    end
  end

  assign bus.voice_on   = voice_on_q;
  assign bus.voice_key  = vkey_q;
  assign bus.voice_trig = trig_q;
  assign bus.steal      = steal_q;
  assign bus.voice_rank = rank_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: vector table for allocation/steal, plus
// hand sequences for dropped pending keys, Enable toggling and async reset.
module tb_voice_allocator;
  logic CLK;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  voice_allocator_if bus ();

  voice_allocator dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        en;
    logic [7:0]  keys;
    logic [3:0]  on;
    logic [3:0]  trig;
    logic        steal;
    logic [11:0] vkey;   // {v3,v2,v1,v0}, 3 bits each
    logic [7:0]  rank;   // {v3,v2,v1,v0}, 2 bits each
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] on, input logic [3:0] trig,
                         input logic st, input logic [11:0] vkey, input logic [7:0] rank);
    chk({tag, " voice_on"},   32'(bus.voice_on),   32'(on));
    chk({tag, " voice_trig"}, 32'(bus.voice_trig), 32'(trig));
    chk({tag, " steal"},      32'(bus.steal),      32'(st));
    chk({tag, " voice_key"},  32'(bus.voice_key),  32'(vkey));
    chk({tag, " voice_rank"}, 32'(bus.voice_rank), 32'(rank));
  endtask

  initial begin
    // single key, then keys 0..3 together, then a steal by key 5
    tbl[0]  = '{1'b1, 8'h04, 4'b0001, 4'b0001, 1'b0, 12'h002, 8'hE4};
    tbl[1]  = '{1'b1, 8'h04, 4'b0001, 4'b0000, 1'b0, 12'h002, 8'hE4};
    tbl[2]  = '{1'b1, 8'h00, 4'b0000, 4'b0000, 1'b0, 12'h002, 8'hE4};
    tbl[3]  = '{1'b1, 8'h0F, 4'b0001, 4'b0001, 1'b0, 12'h000, 8'hE4};
    tbl[4]  = '{1'b1, 8'h0F, 4'b0011, 4'b0010, 1'b0, 12'h008, 8'hE1};
    tbl[5]  = '{1'b1, 8'h0F, 4'b0111, 4'b0100, 1'b0, 12'h088, 8'hC6};
    tbl[6]  = '{1'b1, 8'h0F, 4'b1111, 4'b1000, 1'b0, 12'h688, 8'h1B};
    tbl[7]  = '{1'b1, 8'h0F, 4'b1111, 4'b0000, 1'b0, 12'h688, 8'h1B};
    tbl[8]  = '{1'b1, 8'h2F, 4'b1111, 4'b0001, 1'b1, 12'h68D, 8'h6C};
    tbl[9]  = '{1'b1, 8'h2F, 4'b1111, 4'b0000, 1'b0, 12'h68D, 8'h6C};
    tbl[10] = '{1'b1, 8'h2E, 4'b1111, 4'b0000, 1'b0, 12'h68D, 8'h6C};
    tbl[11] = '{1'b1, 8'h00, 4'b0000, 4'b0000, 1'b0, 12'h68D, 8'h6C};

    RESET      = 1'b1;
    bus.Enable = 1'b0;
    bus.keys   = 8'h00;
    #1;
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 12'h000, 8'hE4);
    step();
    step();
    #2 RESET = 1'b0;

    for (int i = 0; i < 12; i++) begin
      bus.Enable = tbl[i].en;
      bus.keys   = tbl[i].keys;
      step();
      chk_all($sformatf("row%0d", i), tbl[i].on, tbl[i].trig, tbl[i].steal,
              tbl[i].vkey, tbl[i].rank);
    end

    // keys 0..4 together, key 4 released before it is serviced
    bus.keys = 8'h1F;
    step();
    chk("drop trig0", 32'(bus.voice_trig), 32'h1);
    bus.keys = 8'h0F;
    for (int i = 1; i < 4; i++) begin
      step();
      chk($sformatf("drop trig%0d", i), 32'(bus.voice_trig), 32'(4'b0001 << i));
    end
    chk("drop vkey", 32'(bus.voice_key), 32'h688);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("drop idle trig%0d", i), 32'(bus.voice_trig), 32'h0);
      chk($sformatf("drop idle on%0d", i), 32'(bus.voice_on), 32'hF);
    end
    bus.keys = 8'h0D;
    step();
    chk("release key1 on", 32'(bus.voice_on), 32'hD);
    chk("release key1 trig", 32'(bus.voice_trig), 32'h0);

    // Enable low with keys 0,1 held, then re-enable
    bus.keys = 8'h00;
    step();
    chk("en all off", 32'(bus.voice_on), 32'h0);
    bus.keys = 8'h03;
    step();
    chk("en pre trig0", 32'(bus.voice_trig), 32'h1);
    step();
    chk("en pre trig1", 32'(bus.voice_trig), 32'h2);
    chk("en pre on", 32'(bus.voice_on), 32'h3);
    bus.Enable = 1'b0;
    step();
    chk("en low on", 32'(bus.voice_on), 32'h0);
    chk("en low trig", 32'(bus.voice_trig), 32'h0);
    step();
    chk("en low hold on", 32'(bus.voice_on), 32'h0);
    chk("en low hold trig", 32'(bus.voice_trig), 32'h0);
    bus.Enable = 1'b1;
    step();
    chk("reen trig0", 32'(bus.voice_trig), 32'h1);
    chk("reen on0", 32'(bus.voice_on), 32'h1);
    step();
    chk("reen trig1", 32'(bus.voice_trig), 32'h2);
    chk("reen on1", 32'(bus.voice_on), 32'h3);

    // async reset between edges while key 3 is still pending
    bus.keys = 8'h0F;
    step();
    chk("rst pre trig", 32'(bus.voice_trig), 32'h4);
    chk("rst pre on", 32'(bus.voice_on), 32'h7);
    #3 RESET = 1'b1;
    #1;
    chk_all("async rst", 4'b0000, 4'b0000, 1'b0, 12'h000, 8'hE4);
    bus.keys = 8'h00;
    step();
    #2 RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post rst trig%0d", i), 32'(bus.voice_trig), 32'h0);
      chk($sformatf("post rst on%0d", i), 32'(bus.voice_on), 32'h0);
    end
    bus.keys = 8'h01;
    step();
    chk("post rst new trig", 32'(bus.voice_trig), 32'h1);
    chk("post rst new on", 32'(bus.voice_on), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
